// File: rtl/barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: the shift mode encoding and
// the default operand width.
package barrel_shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational shift level: right shift by SHIFT with a fill bit, or a
// rotate when BARREL_ROTATE_EN is defined. The stage register lives in the parent.
module barrel_shift_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT      = 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  en_i,
    input  logic                  fill_i,
`ifdef BARREL_ROTATE_EN
    input  logic                  wrap_i,
`endif
    output logic [DATA_WIDTH-1:0] data_o
);

    // Shift, fill or wrap this level when its shamt bit is set
    always_comb begin
        data_o = data_i;
        if (en_i) begin
`ifdef BARREL_ROTATE_EN
            if (wrap_i) begin
                data_o = {data_i[SHIFT-1:0], data_i[DATA_WIDTH-1:SHIFT]};
            end else begin
                data_o = {{SHIFT{fill_i}}, data_i[DATA_WIDTH-1:SHIFT]};
            end
`else
            data_o = {{SHIFT{fill_i}}, data_i[DATA_WIDTH-1:SHIFT]};
`endif
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined LSL/LSR/ASR/ROR barrel shifter, one register per shift level,
// global stall on the output handshake. Define BARREL_ROTATE_EN to build ROR.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int  TAG_WIDTH   = 4,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic [1:0]             in_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int LAST = SHAMT_WIDTH - 1;

    typedef struct packed {
        shift_mode_t            mode;
        logic [SHAMT_WIDTH-1:0] shamt;
        logic                   fill;
    } ctl_t;

    logic [DATA_WIDTH-1:0] data_q   [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0] data_d   [SHAMT_WIDTH];
    logic [TAG_WIDTH-1:0]  tag_q    [SHAMT_WIDTH];
    logic                  valid_q  [SHAMT_WIDTH];
    ctl_t                  ctl_q    [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0] stg_in_s [SHAMT_WIDTH];
    logic [DATA_WIDTH-1:0] stg_out_s[SHAMT_WIDTH];
    ctl_t                  stg_ctl_s[SHAMT_WIDTH];
    ctl_t                  entry_ctl_s;
    logic                  adv_s;

    function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            r[b] = v[DATA_WIDTH-1-b];
        end
        return r;
    endfunction

    assign adv_s     = !valid_q[LAST] || out_ready;
    assign in_ready  = adv_s && !rst;
    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_tag   = tag_q[LAST];

    // Entry control and per-level inputs; LSL is done as a right shift of the reversed operand
    always_comb begin
        entry_ctl_s.mode  = shift_mode_t'(in_mode);
        entry_ctl_s.shamt = in_shamt;
        if (shift_mode_t'(in_mode) == MODE_ASR) begin
            entry_ctl_s.fill = in_data[DATA_WIDTH-1];
        end else begin
            entry_ctl_s.fill = 1'b0;
        end
        if (shift_mode_t'(in_mode) == MODE_LSL) begin
            stg_in_s[0] = bit_reverse(in_data);
        end else begin
            stg_in_s[0] = in_data;
        end
        stg_ctl_s[0] = entry_ctl_s;
        for (int i = 1; i < SHAMT_WIDTH; i++) begin
            stg_in_s[i]  = data_q[i-1];
            stg_ctl_s[i] = ctl_q[i-1];
        end
    end

    // Level i handles shift amount bit SHAMT_WIDTH-1-i, largest shift first
    for (genvar i = 0; i < SHAMT_WIDTH; i++) begin : g_stage
        localparam int K = SHAMT_WIDTH - 1 - i;
        barrel_shift_stage #(
            .DATA_WIDTH(DATA_WIDTH),
            .SHIFT     (32'd1 << K)
        ) u_stage (
            .data_i(stg_in_s[i]),
            .en_i  (stg_ctl_s[i].shamt[K]),
            .fill_i(stg_ctl_s[i].fill),
`ifdef BARREL_ROTATE_EN
            .wrap_i(stg_ctl_s[i].mode == MODE_ROR),
`endif
            .data_o(stg_out_s[i])
        );
    end

    // Next-state data, undoing the LSL reversal ahead of the output register
    always_comb begin
        for (int i = 0; i < SHAMT_WIDTH; i++) begin
            data_d[i] = stg_out_s[i];
        end
        if (stg_ctl_s[LAST].mode == MODE_LSL) begin
            data_d[LAST] = bit_reverse(stg_out_s[LAST]);
        end else begin
            data_d[LAST] = stg_out_s[LAST];
        end
    end

    // Pipeline registers: whole pipe advances together, bubbles included
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SHAMT_WIDTH; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                ctl_q[i]   <= '0;
            end
        end else if (adv_s) begin
            valid_q[0] <= in_valid && in_ready;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < SHAMT_WIDTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
            for (int i = 0; i < SHAMT_WIDTH; i++) begin
                data_q[i] <= data_d[i];
                ctl_q[i]  <= stg_ctl_s[i];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at DATA_WIDTH=8: directed
// cases, latency, stall, reset flush and a random regression.
module tb_pipelined_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic [1:0] in_mode = 2'b00;
    logic [3:0] in_tag = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_tag;

    typedef struct {
        logic [7:0] d;
        logic [3:0] t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;
    int   rcvd_cnt = 0;

    pipelined_barrel_shifter #(.DATA_WIDTH(8), .TAG_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        logic [15:0] dd;
        logic [7:0]  r;
        dd = 16'h0000;
        case (m)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $signed(d) >>> s;
`ifdef BARREL_ROTATE_EN
            2'b11: begin dd = {d, d} >> s; r = dd[7:0]; end
`else
            2'b11: r = d >> s;
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for accept, push its expected result
    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                        input logic [3:0] t, input bit rnd);
        exp_t e;
        bit   accepted;
        int   budget;
        in_data = d; in_shamt = s; in_mode = m; in_tag = t; in_valid = 1'b1;
        accepted = 1'b0;
        budget = 0;
        while (!accepted && budget < 200) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = model(d, s, m);
                e.t = t;
                sb.push_back(e);
                acc_cnt++;
                accepted = 1'b1;
            end else begin
                budget++;
                @(posedge clk); #1;
                if (rnd) out_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("accept_timeout", 32'(accepted), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: every output transfer must match the oldest expected beat
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("unexpected_output", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_tag", 32'(out_tag), 32'(e.t));
                rcvd_cnt++;
            end
        end
    end

    initial begin
        int n;
        int acc0;
        int rcv0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // LSL with exact latency
        out_ready = 1'b1;
        send(8'hB5, 3'd3, 2'b00, 4'h5, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 20);
        chk("lsl_latency", 32'(n), 32'd3);
        chk("lsl_value_model", 32'(model(8'hB5, 3'd3, 2'b00)), 32'h0000_00A8);
        @(posedge clk); #1;

        // Directed modes back to back, plus shamt 0 in every mode
        send(8'hB5, 3'd3, 2'b01, 4'h1, 1'b0);
        send(8'hB5, 3'd3, 2'b10, 4'h2, 1'b0);
        send(8'h35, 3'd3, 2'b10, 4'h3, 1'b0);
        send(8'hB5, 3'd3, 2'b11, 4'h4, 1'b0);
        send(8'hB5, 3'd7, 2'b00, 4'h6, 1'b0);
        send(8'h81, 3'd7, 2'b10, 4'h7, 1'b0);
        send(8'h81, 3'd1, 2'b11, 4'h8, 1'b0);
        for (int m = 0; m < 4; m++) begin
            send(8'hB5, 3'd0, 2'(m), 4'(9 + m), 1'b0);
        end
        drain();

        // Stall: three beats fill the pipe, fourth waits at the input
        out_ready = 1'b0;
        send(8'hB5, 3'd2, 2'b01, 4'hA, 1'b0);
        send(8'hC3, 3'd5, 2'b00, 4'hB, 1'b0);
        send(8'h96, 3'd1, 2'b10, 4'hC, 1'b0);
        in_data = 8'h5A; in_shamt = 3'd4; in_mode = 2'b11; in_tag = 4'hD; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", 32'(out_data), 32'(sb[0].d));
            chk("stall_out_tag", 32'(out_tag), 32'(sb[0].t));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            sb.push_back('{d: model(8'h5A, 3'd4, 2'b11), t: 4'hD});
            acc_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("release_stream_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Reset with two beats in flight: both discarded
        send(8'h11, 3'd1, 2'b00, 4'h1, 1'b0);
        send(8'h22, 3'd2, 2'b01, 4'h2, 1'b0);
        rst = 1'b1;
        sb.delete();
        acc_cnt = rcvd_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("flush_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Random regression with toggling out_ready
        acc0 = acc_cnt;
        rcv0 = rcvd_cnt;
        for (int b = 0; b < 10000; b++) begin
            send(8'($urandom), 3'($urandom), 2'($urandom), 4'($urandom), 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        drain();
        chk("rand_accepted", 32'(acc_cnt - acc0), 32'd10000);
        chk("rand_received", 32'(rcvd_cnt - rcv0), 32'd10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
